// File: rtl/seq_gen_01110_if.sv
// seq_gen_01110_if: request/status and dual-rail symbol bundle of the 01110 pattern transmitter
interface seq_gen_01110_if #(
    parameter int REP_W = 4
);
    logic             start;
    logic [REP_W-1:0] reps;
    logic             hold;
    logic             A;
    logic             B;
    logic             sym_vld;
    logic             last_bit;
    logic             busy;
    logic             done;
    modport master (output start, reps, hold, input A, B, sym_vld, last_bit, busy, done);
    modport slave (input start, reps, hold, output A, B, sym_vld, last_bit, busy, done);
endinterface

// File: rtl/seq_gen_01110.sv
// seq_gen_01110: repeats a fixed pattern MSB-first on a dual-rail pair with idle gaps between copies
module seq_gen_01110 #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b01110,
    parameter int               GAP     = 2,
    parameter int               REP_W   = 4
) (
    input logic              clk,
    input logic              clr,
    seq_gen_01110_if.slave   bus
);
    localparam int IW = $clog2(PAT_W);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;
    state_t           st, nst;
    logic [IW-1:0]    idx, nidx;
    logic [GW-1:0]    gcnt, ngcnt;
    logic [REP_W-1:0] rcnt, nrcnt;
    logic             stall, nstall, nvld;
    // stall marks the current cycle as held; position only advances on non-stalled cycles
    always_comb begin
        nst = st;
        nidx = idx;
        ngcnt = gcnt;
        nrcnt = rcnt;
        case (st)
            S_SEND: if (!stall) begin
                if (idx != '0) nidx = idx - 1'b1;
                else begin
                    nrcnt = rcnt - 1'b1;
                    nidx = IW'(PAT_W - 1);
                    ngcnt = '0;
                    nst = (rcnt == REP_W'(1)) ? S_FIN : (GAP > 0) ? S_GAP : S_SEND;
                end
            end
            S_GAP: if (!stall) begin
                ngcnt = gcnt + 1'b1;
                nidx = IW'(PAT_W - 1);
                nst = (gcnt == GW'(GAP - 1)) ? S_SEND : S_GAP;
            end
            default: begin
                nidx = IW'(PAT_W - 1);
                nrcnt = bus.reps;
                nst = !bus.start ? S_IDLE : (bus.reps != '0) ? S_SEND : S_FIN;
            end
        endcase
        nstall = bus.hold && (nst == S_SEND || nst == S_GAP);
        nvld = (nst == S_SEND) && !nstall;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            st <= S_IDLE;
            idx <= '0;
            gcnt <= '0;
            rcnt <= '0;
            stall <= 1'b0;
            bus.A <= 1'b0;
            bus.B <= 1'b0;
            bus.sym_vld <= 1'b0;
            bus.last_bit <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            st <= nst;
            idx <= nidx;
            gcnt <= ngcnt;
            rcnt <= nrcnt;
            stall <= nstall;
            bus.A <= nvld && !PATTERN[nidx];
            bus.B <= nvld && PATTERN[nidx];
            bus.sym_vld <= nvld;
            bus.last_bit <= nvld && (nidx == '0);
            bus.busy <= (nst == S_SEND) || (nst == S_GAP);
            bus.done <= nst == S_FIN;
        end
    end
endmodule

// File: tb/tb_seq_gen_01110.sv
// tb_seq_gen_01110: directed vector table plus hand-written multi-cycle sequences
module tb_seq_gen_01110;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    seq_gen_01110_if #(.REP_W(4)) bus ();
    seq_gen_01110 #(.PAT_W(5), .PATTERN(5'b01110), .GAP(2), .REP_W(4)) dut (.clk(clk), .clr(clr), .bus(bus));
    logic [5:0] obs;
    assign obs = {bus.A, bus.B, bus.sym_vld, bus.last_bit, bus.busy, bus.done};
    typedef struct {
        logic       start;
        logic [3:0] reps;
        logic       hold;
        logic [5:0] exp;
        string      nm;
    } vec_t;
    vec_t tbl[$];
    logic [5:0] cyc6 [6];
    logic [5:0] exp5 [5];
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic tick(input logic st, input logic [3:0] rp, input logic hd);
        @(negedge clk);
        bus.start = st;
        bus.reps = rp;
        bus.hold = hd;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int nb, nl, nd, fires;
        logic [31:0] vpat, bpat;
        logic [4:0] sh;
        // obs = {A, B, sym_vld, last_bit, busy, done}
        tbl.push_back('{1'b1, 4'd1, 1'b0, 6'b101010, "t1_b4"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t1_b3"});
        tbl.push_back('{1'b1, 4'd5, 1'b0, 6'b011010, "t1_b2_start_ignored"});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 6'b011010, "t1_b1"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b101110, "t1_b0_last"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b000001, "t1_done"});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 6'b000000, "t1_idle_hold"});
        tbl.push_back('{1'b1, 4'd0, 1'b0, 6'b000001, "t4_reps0_done"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b000000, "t4_idle"});
        tbl.push_back('{1'b1, 4'd2, 1'b0, 6'b101010, "t3_c1_b4"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t3_c1_b3"});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 6'b000010, "t3_hold1"});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 6'b000010, "t3_hold2"});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 6'b000010, "t3_hold3"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t3_c1_b2"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t3_c1_b1"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b101110, "t3_c1_b0"});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 6'b000010, "t3_gap_held"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b000010, "t3_gap1"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b000010, "t3_gap2"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b101010, "t3_c2_b4"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t3_c2_b3"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t3_c2_b2"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b011010, "t3_c2_b1"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b101110, "t3_c2_b0"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b000001, "t3_done"});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 6'b000000, "t3_idle"});
        cyc6 = '{6'b101010, 6'b011010, 6'b011010, 6'b011010, 6'b101110, 6'b000001};
        exp5 = '{6'b011010, 6'b011010, 6'b011010, 6'b101110, 6'b000001};
        bus.start = 1'b0;
        bus.reps = '0;
        bus.hold = 1'b0;
        #1;
        chk("reset_outputs", obs, 0);
        repeat (2) @(negedge clk);
        chk("reset_clocked", obs, 0);
        clr = 1'b1;
        tick(1'b0, 4'd0, 1'b0);
        chk("idle_after_reset", obs, 0);
        foreach (tbl[i]) begin
            tick(tbl[i].start, tbl[i].reps, tbl[i].hold);
            chk(tbl[i].nm, obs, tbl[i].exp);
        end
        tick(1'b1, 4'd3, 1'b0);
        nb = 0; nl = 0; nd = 0; vpat = '0; bpat = '0;
        for (int i = 0; i < 30; i++) begin
            if (bus.busy) begin
                nb++;
                vpat = {vpat[30:0], bus.sym_vld};
            end
            if (bus.sym_vld) bpat = {bpat[30:0], bus.B};
            nl += int'(bus.last_bit);
            nd += int'(bus.done);
            tick(1'b0, 4'd9, 1'b0);
        end
        chk("t2_busy_cycles", nb, 19);
        chk("t2_last_pulses", nl, 3);
        chk("t2_done_pulses", nd, 1);
        chk("t2_vld_pattern", vpat, 32'b1111100111110011111);
        chk("t2_b_pattern", bpat, 32'b011100111001110);
        tick(1'b1, 4'd1, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        chk("t5_mid_bit", obs, 6'b011010);
        #2 clr = 1'b0;
        #1 chk("t5_async_clear", obs, 0);
        @(negedge clk);
        clr = 1'b1;
        tick(1'b0, 4'd0, 1'b0);
        chk("t5_no_resume", obs, 0);
        tick(1'b1, 4'd1, 1'b0);
        chk("t5_restart_b4", obs, 6'b101010);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 4'd0, 1'b0);
            chk($sformatf("t5_seq%0d", i), obs, exp5[i]);
        end
        fires = 0; sh = '0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 4'd1, 1'b0);
            chk($sformatf("t6_cyc%0d", i), obs, cyc6[i % 6]);
            if (bus.sym_vld) begin
                sh = {sh[3:0], bus.B};
                if (sh == 5'b01110) fires++;
            end
            nd += int'(bus.done);
        end
        chk("t6_detector_fires", fires, 2);
        chk("t6_done_count", nd, 2);
        tick(1'b0, 4'd0, 1'b0);
        chk("t6_idle", obs, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
